// File: rtl/step_shift_reg_pkg.sv
// Shared types for the step-driven shift register: FSM states and shift direction.
package shift_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } shift_state_t;

  typedef enum logic {
    DIR_LEFT  = 1'b0,
    DIR_RIGHT = 1'b1
  } shift_dir_t;

  localparam int unsigned WIDTH_MIN = 2;
  localparam int unsigned WIDTH_MAX = 32;

endpackage

// File: rtl/step_shift_reg_rise_detect.sv
// Rising-edge detector turning the divider's square wave into a one-cycle tick.
// With STEP_SYNC_EN defined, a two-flop synchronizer precedes the detector.
module rise_detect
  import shift_pkg::*;
(
  input  logic clock_in,
  input  logic reset,
  input  logic level,
  output logic tick
);

  logic level_s;
  logic level_q_reg;

`ifdef STEP_SYNC_EN
  logic sync1_reg;
  logic sync2_reg;

  // Both stages reset high so a level already high at release is not a new edge.
  always_ff @(posedge clock_in) begin
    if (reset) begin
      sync1_reg <= 1'b1;
      sync2_reg <= 1'b1;
    end else begin
      sync1_reg <= level;
      sync2_reg <= sync1_reg;
    end
  end

  assign level_s = sync2_reg;
`else
  assign level_s = level;
`endif

  always_ff @(posedge clock_in) begin
    if (reset) begin
      level_q_reg <= 1'b1;
    end else begin
      level_q_reg <= level_s;
    end
  end

  assign tick = level_s & ~level_q_reg;

endmodule

// File: rtl/step_shift_reg.sv
// Step-strobed shift register with parallel load and a start-triggered WIDTH-bit shift.
// Optional STEP_SYNC_EN (inside rise_detect) synchronizes an asynchronous step input.
module step_shift_reg
  import shift_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic                         clock_in,
  input  logic                         reset,
  input  logic                         step,
  input  logic                         load,
  input  logic [WIDTH-1:0]             data_in,
  input  logic                         start,
  input  logic                         dir,
  input  logic                         serial_in,
  output logic [WIDTH-1:0]             q,
  output logic                         serial_out,
  output logic                         busy,
  output logic                         done,
  output logic [$clog2(WIDTH+1)-1:0]   bit_cnt
);

  localparam int CNT_W = $clog2(WIDTH+1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  shift_state_t       state_reg, state_next;
  shift_dir_t         dir_reg, dir_next;
  logic [WIDTH-1:0]   q_reg, q_next;
  logic [CNT_W-1:0]   cnt_reg, cnt_next;
  logic               busy_reg, busy_next;
  logic               done_reg, done_next;
  logic               step_tick;
  logic [WIDTH-1:0]   shl_vec;
  logic [WIDTH-1:0]   shr_vec;

  rise_detect u_rise_detect (
    .clock_in (clock_in),
    .reset    (reset),
    .level    (step),
    .tick     (step_tick)
  );

  // Both candidate shift results, serial_in entering at the vacated end.
  generate
    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_shift
      if (gi == 0) begin : g_shl_lsb
        assign shl_vec[gi] = serial_in;
      end else begin : g_shl_mid
        assign shl_vec[gi] = q_reg[gi-1];
      end
      if (gi == WIDTH - 1) begin : g_shr_msb
        assign shr_vec[gi] = serial_in;
      end else begin : g_shr_mid
        assign shr_vec[gi] = q_reg[gi+1];
      end
    end
  endgenerate

  always_ff @(posedge clock_in) begin
    if (reset) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: begin
        if (start && !load) begin
          state_next = SHIFT;
        end
      end
      SHIFT: begin
        if (step_tick && (cnt_reg == CNT_LAST)) begin
          state_next = DONE;
        end
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    busy_next = (state_next == SHIFT);
    done_next = (state_next == DONE);
  end

  // Datapath: only IDLE accepts load/start; only SHIFT reacts to ticks.
  always_comb begin
    q_next   = q_reg;
    cnt_next = cnt_reg;
    dir_next = dir_reg;
    case (state_reg)
      IDLE: begin
        if (load) begin
          q_next = data_in;
        end else if (start) begin
          dir_next = shift_dir_t'(dir);
          cnt_next = '0;
        end
      end
      SHIFT: begin
        if (step_tick) begin
          q_next   = (dir_reg == DIR_RIGHT) ? shr_vec : shl_vec;
          cnt_next = cnt_reg + CNT_ONE;
        end
      end
      default: begin
        q_next = q_reg;
      end
    endcase
  end

  always_ff @(posedge clock_in) begin
    if (reset) begin
      q_reg    <= '0;
      cnt_reg  <= '0;
      dir_reg  <= DIR_LEFT;
      busy_reg <= 1'b0;
      done_reg <= 1'b0;
    end else begin
      q_reg    <= q_next;
      cnt_reg  <= cnt_next;
      dir_reg  <= dir_next;
      busy_reg <= busy_next;
      done_reg <= done_next;
    end
  end

  assign q          = q_reg;
  assign bit_cnt    = cnt_reg;
  assign busy       = busy_reg;
  assign done       = done_reg;
  assign serial_out = (dir_reg == DIR_RIGHT) ? q_reg[0] : q_reg[WIDTH-1];

endmodule

// File: doc/step_shift_reg.md
Name: step_shift_reg

Overview:
Shift-register stage that sits directly downstream of the clock divider. It runs on the fast system clock and treats the divider's slow square wave as a step strobe. Each rising edge of the strobe advances the register by one bit. It supports parallel load and a start-triggered WIDTH-bit serial shift, with busy/done status for the lab top level and its LED/pin outputs.

Parameters:
WIDTH, 8, register length in bits; legal range 2..32.

Ports:
clock_in  input  1  system clock; same clock that feeds the divider.
reset  input  1  synchronous, active-high reset.
step  input  1  slow square wave from the divider output (level, not a pulse).
load  input  1  parallel-load request.
data_in  input  WIDTH  parallel load value.
start  input  1  begin a WIDTH-bit shift sequence.
dir  input  1  shift direction; 0 = left (toward MSB), 1 = right (toward LSB).
serial_in  input  1  bit inserted at the vacated end on each shift.
q  output  WIDTH  register contents.
serial_out  output  1  bit leaving the register: q[WIDTH-1] when the latched dir is 0, q[0] when it is 1.
busy  output  1  high while in SHIFT.
done  output  1  one-cycle pulse when the sequence completes.
bit_cnt  output  $clog2(WIDTH+1)  shifts performed in the current sequence.

Behaviour:
- Clocking and reset:
  - All state updates on posedge clock_in.
  - Reset is synchronous and active-high; it overrides every other input.
- Reset values:
  - q = 0, bit_cnt = 0, busy = 0, done = 0.
  - FSM state = IDLE; latched dir = 0, so serial_out = 0.
  - step_q = 1, so a step input that is already high at reset release produces no tick.
- Step tick:
  - step_tick = step & ~step_q; step_q <= step every cycle.
  - The tick is a one-cycle pulse, asserted in the cycle after the rising step edge is sampled.
  - A step held high produces exactly one tick.
- FSM states: IDLE, SHIFT, DONE.
- IDLE:
  - load=1: q <= data_in on the next edge; no tick required.
  - start=1 and load=0: latch dir, bit_cnt <= 0, go to SHIFT.
  - load and start both high: load wins and start is ignored.
- SHIFT:
  - busy=1. On each step_tick, shift one position using the latched dir:
    - dir=0: q <= {q[WIDTH-2:0], serial_in}.
    - dir=1: q <= {serial_in, q[WIDTH-1:1]}.
  - bit_cnt increments on each tick.
  - On the tick where bit_cnt == WIDTH-1: perform the final shift, bit_cnt becomes WIDTH, go to DONE.
  - load, start and dir changes are ignored in SHIFT.
- DONE:
  - done=1 for exactly one cycle, then return to IDLE.
  - bit_cnt holds WIDTH until the next start.
  - start or load seen during DONE is ignored.
- Outputs:
  - serial_out is combinational from q and the latched dir.
  - All other outputs are registered.
- Reset mid-SHIFT: immediate return to the reset values; the partial shift is discarded and done is not pulsed.
- Step ticks in IDLE or DONE have no effect on q.

Optional Feature:
STEP_SYNC_EN.
- Defined: step passes through a two-flop synchronizer (both flops reset to 1) before the edge detector. This adds 2 clock_in cycles of tick latency and makes the block safe for a step that is asynchronous to clock_in, such as a debounced button.
- Undefined: step goes straight to the edge detector and must be synchronous to clock_in, as the divider output is.

Decomposition:
- Package shift_pkg:
  - typedef enum logic [1:0] {IDLE, SHIFT, DONE} shift_state_t.
  - typedef enum logic {DIR_LEFT=0, DIR_RIGHT=1} shift_dir_t.
- Sub-module rise_detect: clock_in, reset, level in, tick out, with the optional STEP_SYNC_EN synchronizer inside it.
- The FSM and datapath stay in step_shift_reg.

Test Plan (WIDTH=8, no STEP_SYNC_EN, step driven by the divider with SCALE=2):
- Reset check: assert reset with step high, then release -> q=0, busy=0, done=0, bit_cnt=0, and no tick occurs while step stays high.
- Load in IDLE: load=1, data_in=8'hA5 for one cycle, no step edges -> q=8'hA5 on the next edge; bit_cnt unchanged.
- Left shift: q=8'hA5, start with dir=0, serial_in=0 -> serial_out sequence 1,0,1,0,0,1,0,1. After the 8th tick: q=8'h00, bit_cnt=8, done high for 1 cycle, busy=1 exactly from the start cycle until DONE.
- Right shift: q=8'h81, start with dir=1, serial_in=1 -> after 8 ticks q=8'hFF. Toggling dir and pulsing load mid-sequence changes nothing.
- Priority: load and start together with data_in=8'h3C -> q=8'h3C and the FSM stays in IDLE. A start during the DONE cycle is ignored and busy stays 0.
- Reset mid-SHIFT: after 3 ticks assert reset for 1 cycle -> q=0, bit_cnt=0, IDLE, no done pulse. Repeat the 3-tick run with STEP_SYNC_EN defined -> each q update lags its step rising edge by 2 more cycles.
